// File: rtl/lc3b_cache_pkg.sv
// lc3b_cache_pkg: shared types, FSM encoding and byte-mask helper for the LC-3b cache.
// Revision 1.0
`default_nettype none

package lc3b_cache_pkg;

   typedef logic [127:0] lc3b_block;
   typedef logic [15:0]  lc3b_word;
   typedef logic [1:0]   lc3b_mem_wmask;
   typedef logic [2:0]   lc3b_index;
   typedef logic [2:0]   lc3b_offset3;
   typedef logic [8:0]   lc3b_tag;

   typedef enum logic [1:0] {
      S_CHECK     = 2'd0,
      S_WRITEBACK = 2'd1,
      S_ALLOCATE  = 2'd2
   } cache_state_t;

   localparam int NUM_SETS = 8;

   // Places a 2-bit word byte-enable onto the 16-byte line at word position.
   function automatic logic [15:0] byte_mask(input lc3b_offset3 word, input lc3b_mem_wmask be);
      logic [15:0] m;
      m = {14'b0, be};
      return m << {word, 1'b0};
   endfunction

endpackage

`default_nettype wire

// File: rtl/lc3b_cache_way.sv
// cache_way: one way of the cache - 8 lines of data/tag/valid/dirty, async read by index.
// Revision 1.0
`default_nettype none

module cache_way
   import lc3b_cache_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  lc3b_index   i_index,
   input  logic        i_we,
   input  logic [15:0] i_byte_mask,
   input  lc3b_block   i_wline,
   input  logic        i_fill,
   input  lc3b_tag     i_wtag,
   input  logic        i_set_dirty,
   output lc3b_block   o_line,
   output lc3b_tag     o_tag,
   output logic        o_valid,
   output logic        o_dirty
);

   lc3b_block           r_data [NUM_SETS];
   lc3b_tag             r_tag  [NUM_SETS];
   logic [NUM_SETS-1:0] r_valid;
   logic [NUM_SETS-1:0] r_dirty;

   // Data and tag storage carry no reset; valid gates their use.
   always_ff @(posedge clk) begin
      if (i_we) begin
         for (int b = 0; b < 16; b++) begin
            if (i_byte_mask[b]) r_data[i_index][8*b +: 8] <= i_wline[8*b +: 8];
         end
      end
      if (i_fill) r_tag[i_index] <= i_wtag;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         r_dirty <= '0;
      end else if (i_fill) begin
         r_valid[i_index] <= 1'b1;
         r_dirty[i_index] <= 1'b0;
      end else if (i_set_dirty) begin
         r_dirty[i_index] <= 1'b1;
      end
   end

   assign o_line  = r_data[i_index];
   assign o_tag   = r_tag[i_index];
   assign o_valid = r_valid[i_index];
   assign o_dirty = r_dirty[i_index];

endmodule

`default_nettype wire

// File: rtl/lc3b_cache.sv
// lc3b_cache: 2-way set-associative write-back/write-allocate cache, 8 sets x 16-byte lines.
// Revision 1.0
`default_nettype none

module lc3b_cache
   import lc3b_cache_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic [15:0]   mem_address,
   input  logic          mem_read,
   input  logic          mem_write,
   input  lc3b_mem_wmask mem_byte_enable,
   input  lc3b_word      mem_wdata,
   output lc3b_word      mem_rdata,
   output logic          mem_resp,
   output logic [15:0]   pmem_address,
   output logic          pmem_read,
   output logic          pmem_write,
   output lc3b_block     pmem_wdata,
   input  lc3b_block     pmem_rdata,
   input  logic          pmem_resp
);

   cache_state_t r_state;
   logic [7:0]   r_lru;
   logic         r_pmem_read;
   logic         r_pmem_write;

   lc3b_tag     w_tag;
   lc3b_index   w_index;
   lc3b_offset3 w_word;
   lc3b_block   w_line [2];
   lc3b_tag     w_way_tag [2];
   logic [1:0]  w_valid, w_dirty, w_hit_way;
   logic [1:0]  w_we, w_fill, w_set_dirty, w_hit_oh, w_victim_oh;
   logic        w_req, w_hit, w_hit_sel, w_victim, w_victim_dirty;
   logic        w_check_hit, w_wr_hit, w_fill_now;
   lc3b_block   w_wline, w_line_sel;
   logic [15:0] w_mask;
   logic        w_unused;

   assign w_tag    = mem_address[15:7];
   assign w_index  = mem_address[6:4];
   assign w_word   = mem_address[3:1];
   assign w_unused = mem_address[0];

   generate
      for (genvar g = 0; g < 2; g++) begin : g_way
         cache_way u_way (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_index     (w_index),
            .i_we        (w_we[g]),
            .i_byte_mask (w_mask),
            .i_wline     (w_wline),
            .i_fill      (w_fill[g]),
            .i_wtag      (w_tag),
            .i_set_dirty (w_set_dirty[g]),
            .o_line      (w_line[g]),
            .o_tag       (w_way_tag[g]),
            .o_valid     (w_valid[g]),
            .o_dirty     (w_dirty[g])
         );
         assign w_hit_way[g] = w_valid[g] && (w_way_tag[g] == w_tag);
      end
   endgenerate

   assign w_req     = mem_read | mem_write;
   assign w_hit     = |w_hit_way;
   assign w_hit_sel = w_hit_way[1];
   // Invalid ways are filled first; otherwise replace the least recently used.
   assign w_victim       = !w_valid[0] ? 1'b0 : (!w_valid[1] ? 1'b1 : r_lru[w_index]);
   assign w_victim_dirty = w_valid[w_victim] && w_dirty[w_victim];
   assign w_hit_oh       = {w_hit_sel, ~w_hit_sel};
   assign w_victim_oh    = {w_victim, ~w_victim};

   assign w_check_hit = (r_state == S_CHECK) && w_req && w_hit;
   assign w_wr_hit    = w_check_hit && mem_write && (|mem_byte_enable);
   assign w_fill_now  = (r_state == S_ALLOCATE) && pmem_resp;

   assign w_we        = (w_wr_hit ? w_hit_oh : 2'b00) | (w_fill_now ? w_victim_oh : 2'b00);
   assign w_fill      = w_fill_now ? w_victim_oh : 2'b00;
   assign w_set_dirty = w_wr_hit ? w_hit_oh : 2'b00;
   assign w_wline     = w_fill_now ? pmem_rdata : {8{mem_wdata}};
   assign w_mask      = w_fill_now ? 16'hFFFF : byte_mask(w_word, mem_byte_enable);

   assign w_line_sel   = w_line[w_hit_sel];
   assign mem_rdata    = w_line_sel[{w_word, 4'b0} +: 16];
   assign mem_resp     = w_check_hit;
   assign pmem_wdata   = w_line[w_victim];
   assign pmem_address = (r_state == S_WRITEBACK) ? {w_way_tag[w_victim], w_index, 4'b0}
                                                  : {mem_address[15:4], 4'b0};
   assign pmem_read    = r_pmem_read;
   assign pmem_write   = r_pmem_write;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_CHECK;
         r_lru        <= '0;
         r_pmem_read  <= 1'b0;
         r_pmem_write <= 1'b0;
      end else begin
         case (r_state)
            S_CHECK: begin
               if (w_req) begin
                  if (w_hit) begin
                     r_lru[w_index] <= ~w_hit_sel;
                  end else if (w_victim_dirty) begin
                     r_state      <= S_WRITEBACK;
                     r_pmem_write <= 1'b1;
                  end else begin
                     r_state     <= S_ALLOCATE;
                     r_pmem_read <= 1'b1;
                  end
               end
            end
            S_WRITEBACK: begin
               if (pmem_resp) begin
                  r_state      <= S_ALLOCATE;
                  r_pmem_write <= 1'b0;
                  r_pmem_read  <= 1'b1;
               end
            end
            S_ALLOCATE: begin
               if (pmem_resp) begin
                  r_state     <= S_CHECK;
                  r_pmem_read <= 1'b0;
               end
            end
            default: begin
               r_state      <= S_CHECK;
               r_pmem_read  <= 1'b0;
               r_pmem_write <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
